// File: rtl/blocpu_seq_core.sv
// blocpu_seq_core: multi-cycle accumulator core for the 8-opcode ISA.
// Each instruction runs FETCH -> DECODE -> EXECUTE. Output bytes stall in
// OUT_WAIT until the consumer accepts them. Instructions come from an
// external ROM whose data is valid the cycle after imem_addr is issued.
// The data RAM is internal and keeps its contents across reset.
module blocpu_seq_core #(
  parameter int                   CPU_WIDTH         = 8,
  parameter int                   INSTRUCTION_WIDTH = CPU_WIDTH + 4,
  parameter int                   RAM_DEPTH         = 1 << CPU_WIDTH,
  parameter logic [CPU_WIDTH-1:0] SEL_EXIT          = CPU_WIDTH'('h14),
  parameter logic [CPU_WIDTH-1:0] SEL_HALT          = CPU_WIDTH'('h13)
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         start,
  output logic [CPU_WIDTH-1:0]         imem_addr,
  input  logic [INSTRUCTION_WIDTH-1:0] imem_data,
  output logic                         out_valid,
  output logic [CPU_WIDTH-1:0]         out_data,
  input  logic                         out_ready,
  output logic                         running,
  output logic                         halted,
  output logic [CPU_WIDTH-1:0]         exit_code
);

  localparam int AW = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;

  localparam logic [2:0] OP_LOAD   = 3'd0;
  localparam logic [2:0] OP_JUMP   = 3'd1;
  localparam logic [2:0] OP_IF     = 3'd2;
  localparam logic [2:0] OP_STORE  = 3'd3;
  localparam logic [2:0] OP_ADD    = 3'd4;
  localparam logic [2:0] OP_SUB    = 3'd5;
  localparam logic [2:0] OP_EXT    = 3'd6;
  localparam logic [2:0] OP_SELECT = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_OUT_WAIT,
    S_HALTED
  } state_t;

  state_t state_reg;
  state_t state_next;

  logic [CPU_WIDTH-1:0]         ip_reg;
  logic [CPU_WIDTH-1:0]         acc_reg;
  logic                         ext_sel_reg;
  logic [CPU_WIDTH-1:0]         imem_addr_reg;
  logic                         out_valid_reg;
  logic [CPU_WIDTH-1:0]         out_data_reg;
  logic [CPU_WIDTH-1:0]         exit_code_reg;
  logic [INSTRUCTION_WIDTH-1:0] instr_reg;
  logic [CPU_WIDTH-1:0]         ram_rdata_reg;

  logic [CPU_WIDTH-1:0] ram_mem [RAM_DEPTH];

  // Data RAM addresses wrap modulo the RAM depth (plain truncation for powers of two).
  function automatic logic [AW-1:0] ram_idx(input logic [CPU_WIDTH-1:0] a);
    return AW'(32'(a) % 32'(RAM_DEPTH));
  endfunction

  // Fields of the instruction latched in DECODE, used during EXECUTE.
  logic [2:0]           opcode;
  logic                 imm_flag;
  logic [CPU_WIDTH-1:0] arg;
  logic [CPU_WIDTH-1:0] operand;
  logic [CPU_WIDTH-1:0] ip_plus1;
  logic [CPU_WIDTH-1:0] ip_plus2;
  logic                 sel_halt;

  assign opcode   = instr_reg[INSTRUCTION_WIDTH-1 -: 3];
  assign imm_flag = instr_reg[INSTRUCTION_WIDTH-4];
  assign arg      = instr_reg[CPU_WIDTH-1:0];
  assign operand  = imm_flag ? arg : ram_rdata_reg;
  assign ip_plus1 = ip_reg + CPU_WIDTH'(1);
  assign ip_plus2 = ip_reg + CPU_WIDTH'(2);
  assign sel_halt = (opcode == OP_SELECT) && (arg == SEL_HALT);

  // Fields of the ROM word as it arrives in DECODE; they steer the RAM read.
  logic                 dec_imm;
  logic [CPU_WIDTH-1:0] dec_arg;

  assign dec_imm = imem_data[INSTRUCTION_WIDTH-4];
  assign dec_arg = imem_data[CPU_WIDTH-1:0];

  // RAM strobes. The write is masked by reset so that a reset landing on a
  // STORE in EXECUTE does not commit it.
  logic ram_we;
  logic ram_re;

  assign ram_we = !reset && (state_reg == S_EXECUTE) && (opcode == OP_STORE);
  assign ram_re = (state_reg == S_DECODE) && !dec_imm;

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic. start only matters in IDLE and HALTED.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE, S_HALTED: begin
        if (start) state_next = S_FETCH;
      end
      S_FETCH:  state_next = S_DECODE;
      S_DECODE: state_next = S_EXECUTE;
      S_EXECUTE: begin
        state_next = S_FETCH;
        if (opcode == OP_EXT) begin
          state_next = ext_sel_reg ? S_HALTED : S_OUT_WAIT;
        end else if (sel_halt) begin
          state_next = S_HALTED;
        end
      end
      S_OUT_WAIT: begin
        if (out_ready) state_next = S_FETCH;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Architectural registers, instruction latch and output channel.
  always_ff @(posedge clock) begin
    if (reset) begin
      ip_reg        <= '0;
      acc_reg       <= '0;
      ext_sel_reg   <= 1'b0;
      imem_addr_reg <= '0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      exit_code_reg <= '0;
      instr_reg     <= '0;
    end else begin
      case (state_reg)
        S_IDLE, S_HALTED: begin
          if (start) begin
            ip_reg        <= '0;
            acc_reg       <= '0;
            ext_sel_reg   <= 1'b0;
            exit_code_reg <= '0;
          end
        end
        S_FETCH: begin
          imem_addr_reg <= ip_reg;
        end
        S_DECODE: begin
          instr_reg <= imem_data;
        end
        S_EXECUTE: begin
          case (opcode)
            OP_LOAD: begin
              acc_reg <= operand;
              ip_reg  <= ip_plus1;
            end
            OP_JUMP: begin
              ip_reg <= operand;
            end
            OP_IF: begin
              ip_reg <= (operand == acc_reg) ? ip_plus2 : ip_plus1;
            end
            OP_STORE: begin
              ip_reg <= ip_plus1;
            end
            OP_ADD: begin
              acc_reg <= acc_reg + operand;
              ip_reg  <= ip_plus1;
            end
            OP_SUB: begin
              acc_reg <= acc_reg - operand;
              ip_reg  <= ip_plus1;
            end
            OP_EXT: begin
              if (ext_sel_reg) begin
                exit_code_reg <= operand;
              end else begin
                out_data_reg  <= operand;
                out_valid_reg <= 1'b1;
                ip_reg        <= ip_plus1;
              end
            end
            OP_SELECT: begin
              if (sel_halt) begin
                exit_code_reg <= '0;
              end else begin
                if (arg == SEL_EXIT) begin
                  ext_sel_reg <= 1'b1;
                end else if (arg == '0) begin
                  ext_sel_reg <= 1'b0;
                end
                ip_reg <= ip_plus1;
              end
            end
          endcase
        end
        S_OUT_WAIT: begin
          // out_data is left untouched here so it stays stable while valid.
          if (out_ready) out_valid_reg <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

  // Data RAM: one write port for STORE, registered read for memory operands.
  always_ff @(posedge clock) begin
    if (ram_we) ram_mem[ram_idx(operand)] <= acc_reg;
    if (ram_re) ram_rdata_reg <= ram_mem[ram_idx(dec_arg)];
  end

  assign imem_addr = imem_addr_reg;
  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign exit_code = exit_code_reg;
  assign running   = (state_reg == S_FETCH) || (state_reg == S_DECODE) ||
                     (state_reg == S_EXECUTE) || (state_reg == S_OUT_WAIT);
  assign halted    = (state_reg == S_HALTED);

endmodule

// File: doc/blocpu_seq_core.md
Name: blocpu_seq_core

Overview:
- Synthesizable, parametrised successor to the behavioural accumulator core.
- Executes the same 8-opcode accumulator ISA through an explicit multi-cycle FSM.
- Fetches from an external synchronous instruction ROM and keeps an internal data RAM.
- Emits output bytes over a valid/ready handshake and stalls on back-pressure; reports halt and exit code to the testbench/top.

Parameters:
- CPU_WIDTH, 8: datapath, register, IP and RAM address width.
- INSTRUCTION_WIDTH, CPU_WIDTH+4: instruction layout is [IW-1:IW-3] opcode, [IW-4] immediate flag, [CPU_WIDTH-1:0] arg.
- RAM_DEPTH, 1<<CPU_WIDTH: data RAM words; addresses are taken modulo RAM_DEPTH.
- SEL_EXIT, 8'h14 (CPU_WIDTH bits): SELECT arg that routes EXT to the exit channel.
- SEL_HALT, 8'h13 (CPU_WIDTH bits): SELECT arg that halts immediately with exit code 0.

Ports:
- clock  in  1  single clock; all state on posedge.
- reset  in  1  synchronous, active-high.
- start  in  1  pulse; begins execution from IDLE or HALTED.
- imem_addr  out  CPU_WIDTH  instruction address (registered).
- imem_data  in  INSTRUCTION_WIDTH  ROM data, valid 1 cycle after imem_addr.
- out_valid  out  1  output byte available.
- out_data  out  CPU_WIDTH  output byte.
- out_ready  in  1  consumer accepts when out_valid && out_ready.
- running  out  1  high in FETCH/DECODE/EXECUTE/OUT_WAIT.
- halted  out  1  high in HALTED.
- exit_code  out  CPU_WIDTH  valid while halted.

Behaviour:
- Reset values: ip=0, register=0, ext_sel=0, imem_addr=0, out_valid=0, out_data=0, running=0, halted=0, exit_code=0. State goes to IDLE. RAM contents are not cleared.
- Reset mid-operation, including OUT_WAIT with out_valid high: takes effect on the next edge, drops out_valid, and no byte is counted as transferred.
- States: IDLE, FETCH, DECODE, EXECUTE, OUT_WAIT, HALTED.
- IDLE/HALTED --start--> FETCH. On start: ip=0, register=0, ext_sel=0, exit_code=0, halted=0.
- start is ignored while running.
- FETCH: imem_addr<=ip; go to DECODE.
- DECODE: latch imem_data. If the immediate flag is 0, issue a synchronous RAM read at arg. Go to EXECUTE.
- EXECUTE: operand = arg if the immediate flag is 1, otherwise the RAM read data.
- Per-instruction latency is 3 cycles, plus any OUT_WAIT cycles.
- Opcodes, executed in EXECUTE (all arithmetic is modulo 2^CPU_WIDTH; ip+1 and ip+2 also wrap):
  - 000 LOAD: register<=operand; ip+1.
  - 001 JUMP: ip<=operand.
  - 010 IF: ip+2 if operand==register, else ip+1.
  - 011 STORE: ram[operand]<=register; ip+1. A following read of the same address sees the new value.
  - 100 ADD: register+=operand; ip+1. No carry flag.
  - 101 SUB: register-=operand; ip+1. Wraps.
  - 110 EXT:
    - ext_sel=0: out_data<=operand, out_valid<=1, ip+1, go to OUT_WAIT.
    - ext_sel=1: exit_code<=operand, go to HALTED.
  - 111 SELECT:
    - arg 0: ext_sel<=0.
    - SEL_EXIT: ext_sel<=1, no halt.
    - SEL_HALT: exit_code<=0, go to HALTED.
    - Any other value: no-op.
    - ip+1 in all non-halting cases.
- OUT_WAIT: hold out_data and out_valid stable. On out_valid&&out_ready: out_valid<=0, go to FETCH.
  - If out_ready is already high in the first OUT_WAIT cycle, transfer takes exactly 1 cycle.
- out_valid never rises outside EXT, and out_data never changes while out_valid=1.
- HALTED: running=0, halted=1, exit_code held, ip frozen.
- ip wraps from 2^CPU_WIDTH-1 to 0 with no fault.

Test Plan:
- Immediate LOAD 5, ADD 3, SELECT 0, EXT imm 0x08, SELECT 0x14, EXT imm 0x2A; out_ready=1 -> one out transfer with data 0x08; halted=1, exit_code=0x2A; running asserted for the expected 6×3+1 cycles.
- Back-pressure: EXT imm 0x55 with out_ready=0 for 10 cycles, then 1 -> out_valid/out_data=0x55 held for all 10 cycles; exactly one handshake; next imem_addr issued the cycle after.
- Memory operands: LOAD 0x7F, STORE imm 0x10, LOAD imm 0, ADD mem 0x10 -> register=0x7F. Then ADD imm 0x81 -> register=0x00 (wrap).
- IF/JUMP loop: counter decrement from 3 to 0 using IF/JUMP -> exactly 3 loop passes; IF taken skips exactly one instruction; ip wrap from 0xFF fetch to 0x00 observed on imem_addr.
- SELECT 0x13 mid-program -> halted, exit_code=0, no further imem_addr change. start then restarts at ip 0 with register=0 and RAM preserved.
- reset asserted during OUT_WAIT and during EXECUTE -> next edge all outputs at reset values, state IDLE; start ignored while running.
